// File: rtl/cache_pkg.sv
// Shared definitions for the sail-core data cache: load/store size
// encodings, FSM states and the default LED register address.
package cache_pkg;

    // sign_mask[2:0] size encodings; any other value is treated as word
    localparam logic [2:0] SM_BYTE = 3'b001;
    localparam logic [2:0] SM_HALF = 3'b011;
    localparam logic [2:0] SM_WORD = 3'b111;
    // sign_mask[3] selects sign extension on loads
    localparam int         SM_SIGNED = 3;

    localparam logic [31:0] LED_ADDR_DEF = 32'h0000_2000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILL,
        WR_FETCH,
        WR_MERGE
    } state_t;

endpackage

// File: rtl/cache_backing_ram.sv
// Single-port synchronous backing RAM, one-cycle read latency.
// A write cycle returns the old word on rdata.
module cache_backing_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Registered read, optional write to the same address
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cache.sv
// Direct-mapped, write-through / write-allocate data cache with one word
// per line. Misses and stores go through the backing RAM and stall the
// core for two cycles. Also hosts the memory-mapped LED register.
module cache
    import cache_pkg::*;
#(
    parameter int          LINES     = 16,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic [7:0]  led,
    output logic        clk_stall
);

    localparam int IW = $clog2(LINES);
    localparam int RW = $clog2(MEM_WORDS);
    localparam int AW = RW + 2;          // byte address width into the RAM
    localparam int TW = AW - IW - 2;

    // Insert the low lanes of wd into old_w at the lane chosen by off/sz
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] wd,
                                               input logic [1:0]  off,
                                               input logic [2:0]  sz);
        logic [31:0] r;
        r = old_w;
        case (sz)
            SM_BYTE: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            SM_HALF: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Right-align the selected lane and sign- or zero-extend it
    function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                                 input logic [1:0]  off,
                                                 input logic [3:0]  sm);
        logic [31:0] sh;
        logic        sg;
        logic [31:0] r;
        sg = sm[SM_SIGNED];
        case (sm[2:0])
            SM_BYTE: begin
                sh = w >> {off, 3'b000};
                r  = {{24{sg & sh[7]}}, sh[7:0]};
            end
            SM_HALF: begin
                sh = w >> {off[1], 4'b0000};
                r  = {{16{sg & sh[15]}}, sh[15:0]};
            end
            default: begin
                sh = w;
                r  = w;
            end
        endcase
        return r;
    endfunction

    state_t          state;
    logic [AW-1:0]   req_addr;
    logic [31:0]     req_wdata;
    logic [3:0]      req_mask;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    logic [IW-1:0] in_idx, req_idx;
    logic [TW-1:0] in_tag, req_tag;
    logic          hit, is_led;
    logic [31:0]   ram_rdata, merged;
    logic          ram_we;

    // Address decode of the incoming request and the latched one
    always_comb begin
        in_idx  = addr[IW+1:2];
        in_tag  = addr[AW-1:IW+2];
        req_idx = req_addr[IW+1:2];
        req_tag = req_addr[AW-1:IW+2];
        hit     = valid[in_idx] && (tag_arr[in_idx] == in_tag);
        is_led  = (addr == LED_ADDR);
        merged  = lane_merge(ram_rdata, req_wdata, req_addr[1:0], req_mask[2:0]);
        ram_we  = (state == WR_MERGE);
    end

    cache_backing_ram #(
        .WORDS (MEM_WORDS),
        .AW    (RW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_addr[AW-1:2]),
        .wdata (merged),
        .rdata (ram_rdata)
    );

    // Control FSM with registered outputs and valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            read_data <= '0;
            led       <= '0;
            clk_stall <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memwrite) begin
                        if (is_led) begin
                            led <= write_data[7:0];
                        end else begin
                            req_addr  <= addr[AW-1:0];
                            req_wdata <= write_data;
                            req_mask  <= sign_mask;
                            clk_stall <= 1'b1;
                            state     <= WR_FETCH;
                        end
                    end else if (memread) begin
                        if (is_led) begin
                            read_data <= {24'b0, led};
                        end else if (hit) begin
                            read_data <= lane_extract(data_arr[in_idx], addr[1:0], sign_mask);
                        end else begin
                            req_addr  <= addr[AW-1:0];
                            req_wdata <= write_data;
                            req_mask  <= sign_mask;
                            clk_stall <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                FETCH:    state <= FILL;
                FILL: begin
                    valid[req_idx] <= 1'b1;
                    read_data      <= lane_extract(ram_rdata, req_addr[1:0], req_mask);
                    clk_stall      <= 1'b0;
                    state          <= IDLE;
                end
                WR_FETCH: state <= WR_MERGE;
                WR_MERGE: begin
                    valid[req_idx] <= 1'b1;
                    clk_stall      <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    clk_stall <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Tag/data arrays are qualified by valid, so they carry no reset
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= ram_rdata;
        end else if (state == WR_MERGE) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_cache.sv
// Directed bench for the data cache: loads/stores of every size, sign
// extension, conflict misses, the LED register and a mid-store reset.
module tb_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = '0;
    logic [31:0] read_data;
    logic [7:0]  led;
    logic        clk_stall;

    int n_cmp = 0;
    int n_bad = 0;

    cache dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .led        (led),
        .clk_stall  (clk_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request pulse, then count stall cycles (bounded)
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int stalls);
        @(negedge clk);
        addr = a; write_data = d; sign_mask = m;
        memwrite = wr; memread = !wr;
        @(negedge clk);
        memwrite = 1'b0; memread = 1'b0;
        stalls = 0;
        while (clk_stall && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input int exp_stall);
        int s;
        access(1'b1, a, d, m, s);
        chk({tag, "_stall"}, s, exp_stall);
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] exp, input int exp_stall);
        int s;
        access(1'b0, a, 32'h0, m, s);
        chk({tag, "_stall"}, s, exp_stall);
        chk({tag, "_data"}, read_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_led", {24'b0, led}, 32'h0);
        chk("rst_stall", {31'b0, clk_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // byte store / signed and unsigned byte loads
        st("st_b400", 32'h400, 32'h0000_0AAA, 4'b0001, 2);
        chk("ram_b400", {24'b0, dut.u_ram.mem[256][7:0]}, 32'h0000_00AA);
        ld("ld_sb400", 32'h400, 4'b1001, 32'hFFFF_FFAA, 0);
        ld("ld_ub400", 32'h400, 4'b0001, 32'h0000_00AA, 0);
        st("st_b403", 32'h403, 32'h0000_0180, 4'b0001, 2);
        ld("ld_sb403", 32'h403, 4'b1001, 32'hFFFF_FF80, 0);
        ld("ld_ub400b", 32'h400, 4'b0001, 32'h0000_00AA, 0);

        // prime 0x440 for the conflict test
        st("st_w440", 32'h440, 32'h1234_5678, 4'b0111, 2);

        // halfword stores, both halves, addr[0] ignored
        st("st_h100", 32'h100, 32'h0002_AAAA, 4'b0011, 2);
        ld("ld_sh100", 32'h100, 4'b1011, 32'hFFFF_AAAA, 0);
        ld("ld_uh100", 32'h100, 4'b0011, 32'h0000_AAAA, 0);
        st("st_h103", 32'h103, 32'h0000_7123, 4'b0011, 2);
        chk("rdata_held", read_data, 32'h0000_AAAA);
        ld("ld_w100", 32'h100, 4'b0111, 32'h7123_AAAA, 0);
        ld("ld_sh102", 32'h102, 4'b1011, 32'h0000_7123, 0);

        // word store and conflict misses on index 0
        st("st_w40", 32'h40, 32'hAAAA_AAAA, 4'b0111, 2);
        ld("ld_w40", 32'h40, 4'b0111, 32'hAAAA_AAAA, 0);
        ld("ld_w440", 32'h440, 4'b0111, 32'h1234_5678, 2);
        ld("ld_w40m", 32'h40, 4'b0111, 32'hAAAA_AAAA, 2);
        ld("ld_sb441", 32'h441, 4'b1001, 32'h0000_0056, 2);
        ld("ld_sh442", 32'h442, 4'b1011, 32'h0000_1234, 0);
        ld("ld_odd441", 32'h441, 4'b0101, 32'h1234_5678, 0);

        // LED register: no stall, no cache allocation
        st("st_led", 32'h2000, 32'h0000_015A, 4'b0001, 0);
        chk("led_val", {24'b0, led}, 32'h0000_005A);
        ld("ld_led", 32'h2000, 4'b0111, 32'h0000_005A, 0);
        ld("ld_w440h", 32'h440, 4'b0111, 32'h1234_5678, 0);

        // reset in the middle of a store
        st("st_w800", 32'h800, 32'h1111_1111, 4'b0111, 2);
        @(negedge clk);
        addr = 32'h800; write_data = 32'hDEAD_BEEF; sign_mask = 4'b0111;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        chk("wr_fetch_stall", {31'b0, clk_stall}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_led", {24'b0, led}, 32'h0);
        chk("mid_rst_stall", {31'b0, clk_stall}, 32'h0);
        chk("mid_rst_rdata", read_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ram_w800", dut.u_ram.mem[512], 32'h1111_1111);
        ld("ld_w800", 32'h800, 4'b0111, 32'h1111_1111, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
